mem_arbiter: RTL

- Shares the single memory port (ROM/RAM/GPIO address map, 3-bit write_enable encoding) between the CPU instruction-fetch requester and the load/store requester.
- Per-requester req/ready handshake; each access held for a programmable number of wait cycles; read data registered and returned to the winner.
- Sits between the CPU core and the memory top level.

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between the CPU instruction-fetch requester (i_*)
// and the load/store requester (d_*). Each granted access holds the memory
// port for LATENCY cycles. Read data is registered into the owner's rdata
// register, and the owner's ready pulses for one cycle.
//
// Handshake: a requester raises req with its address/data stable and holds
// it until its ready pulses. ready is high for exactly one cycle, and rdata
// is valid from that cycle on until the next read by the same port. The
// arbiter samples requests only in IDLE. A requester that still holds req
// in the IDLE cycle after its ready starts a new transaction, so it must
// drop req in the cycle that follows ready to avoid a repeat. Dropping req
// mid-transaction has no effect: the transaction still completes.
//
// Parameters:
//   LATENCY   memory access cycles per transaction (1..15)
//   DATA_PRIO winner on simultaneous requests: 1 = data, 0 = instruction
//
// Build option:
//   MEM_ARB_RR_EN  when defined, simultaneous requests are resolved
//                  round-robin against a last-grant register, and
//                  DATA_PRIO is ignored.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   i_req/i_addr        instruction fetch request and address
//   i_ready/i_rdata     fetch completion pulse and registered fetch data
//   d_req/d_we/d_addr/d_wdata  load/store request
//                       (d_we: 0 = read, bit0 word, bit1 half, bit2 byte)
//   d_ready/d_rdata     load/store completion pulse and registered load data
//   m_addr/m_we/m_wdata/m_rdata  shared memory port
//   busy                high whenever the FSM is not IDLE
//   grant               {d,i} owner of the current transaction, 00 in IDLE
//   state_dbg           raw FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned LATENCY   = 1,
  parameter bit          DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [2:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [2:0]  m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic [1:0]  grant,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        owner_d;     // 1 = data port owns the transaction
  logic [31:0] lat_addr;
  logic [2:0]  lat_we;
  logic [31:0] lat_wdata;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        any_req;
  logic        pick_d;      // winner if a grant happens this cycle
  logic        last_cycle;  // final ACCESS cycle: commit write / capture read

  assign any_req    = i_req | d_req;
  assign last_cycle = (state == S_ACCESS) && (cnt == 4'd0);

`ifdef MEM_ARB_RR_EN
  // Records which port won the most recent grant (1 = data). It resets to
  // instruction, so the first contended grant goes to the data port.
  logic last_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      last_grant_d <= pick_d;
    end
  end

  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) begin
      pick_d = ~last_grant_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) begin
      pick_d = DATA_PRIO;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (any_req) state_next = S_ACCESS;
      S_ACCESS: if (cnt == 4'd0) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = (state != S_IDLE);
    grant   = 2'b00;
    i_ready = 1'b0;
    d_ready = 1'b0;
    m_we    = 3'b000;
    if (state != S_IDLE) begin
      grant = owner_d ? 2'b10 : 2'b01;
    end
    if (state == S_RESP) begin
      i_ready = ~owner_d;
      d_ready = owner_d;
    end
    // The write enable exists for one cycle only, so each store is committed
    // once. It is also blocked while reset is asserted.
    if (last_cycle && !reset) begin
      m_we = lat_we;
    end
  end

  assign m_addr    = lat_addr;
  assign m_wdata   = lat_wdata;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Datapath: request latch, wait counter, read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      owner_d   <= 1'b0;
      lat_addr  <= 32'd0;
      lat_we    <= 3'b000;
      lat_wdata <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            // Only the winner's inputs are latched. The loser's inputs are
            // picked up when it is eventually granted.
            owner_d   <= pick_d;
            lat_addr  <= pick_d ? d_addr : i_addr;
            lat_we    <= pick_d ? d_we : 3'b000;
            lat_wdata <= pick_d ? d_wdata : 32'd0;
            cnt       <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (lat_we == 3'b000) begin
            // Stores leave the owner's rdata untouched.
            if (owner_d) begin
              d_rdata_q <= m_rdata;
            end else begin
              i_rdata_q <= m_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
